// File: rtl/facto_core_gen.sv
// ---------------------------------------------------------------------------
// facto_core_gen
// Register-mapped factorial / integer-power engine. Software loads OPERAND
// (and BASEV / MODE for power), writes START, and polls STATUS or waits for
// the interrupt. The result is accumulated in a 2*DW-bit register by a
// radix-2 shift-add multiplier that takes DW cycles per multiplication.
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   s_sel      slave select
//   s_wr       1 = write, 0 = read (qualified by s_sel)
//   s_addr     byte address, register offset = s_addr[15:3]
//   s_din      write data (bits above DW ignored)
//   s_dout     registered read data, zero when no read was issued
//   interrupt  DONE and INTR.en
// ---------------------------------------------------------------------------
module facto_core_gen #(
    parameter int          DW   = 64,
    parameter logic [12:0] BASE = 13'hE00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        interrupt
);

    localparam int RW = 2 * DW;
    localparam int PW = RW + DW;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    localparam logic [12:0] OFF_START   = BASE;
    localparam logic [12:0] OFF_CLEAR   = BASE + 13'd1;
    localparam logic [12:0] OFF_STATUS  = BASE + 13'd2;
    localparam logic [12:0] OFF_INTR    = BASE + 13'd3;
    localparam logic [12:0] OFF_OPERAND = BASE + 13'd4;
    localparam logic [12:0] OFF_RES_H   = BASE + 13'd5;
    localparam logic [12:0] OFF_RES_L   = BASE + 13'd6;
    localparam logic [12:0] OFF_MODE    = BASE + 13'd7;
    localparam logic [12:0] OFF_BASEV   = BASE + 13'd8;

    typedef enum logic [2:0] {IDLE, LOAD, MUL, NEXT, DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [PW-1:0] psum_q, psum_d;
    logic [DW-1:0] k_q, k_d;
    logic [DW-1:0] m_q, m_d;
    logic [DW-1:0] fsh_q, fsh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] operand_q, operand_d;
    logic [DW-1:0] basev_q, basev_d;
    logic          mode_q, mode_d;
    logic          run_mode_q, run_mode_d;
    logic          intr_en_q, intr_en_d;
    logic          ovf_q, ovf_d;
    logic [63:0]   s_dout_q, s_dout_d;

    logic [12:0]   off;
    logic          wr_en, rd_en, start_wr, clear_wr;
    logic          busy, done;
    logic [DW-1:0] k_load, m_load, k_next;
    logic [63:0]   rd_data;
    logic          unused_bits;

    function automatic logic [63:0] zext(input logic [DW-1:0] v);
        logic [63:0] r;
        r = '0;
        r[DW-1:0] = v;
        return r;
    endfunction

    assign off      = s_addr[15:3];
    assign wr_en    = s_sel & s_wr;
    assign rd_en    = s_sel & ~s_wr;
    assign start_wr = wr_en & (off == OFF_START) & s_din[0];
    assign clear_wr = wr_en & (off == OFF_CLEAR) & s_din[0];
    assign s_dout   = s_dout_q;
    assign unused_bits = ^{s_addr[2:0], s_din};

    // Operation parameters captured in LOAD; factorial runs k-1 multiplies
    // because the final factor of 1 contributes nothing.
    assign k_load = mode_q ? basev_q : operand_q;
    assign m_load = mode_q ? operand_q
                           : ((operand_q == '0) ? '0 : operand_q - DW'(1));
    assign k_next = run_mode_q ? k_q : k_q - DW'(1);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; CLEAR overrides everything
    always_comb begin
        state_d = state_q;
        if (clear_wr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_wr) state_d = LOAD;
                LOAD:       state_d = (m_load == '0) ? DONE : MUL;
                MUL:        if (cnt_q == CNT_LAST) state_d = NEXT;
                NEXT:       state_d = (m_q == DW'(1)) ? DONE : MUL;
                default:    state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q == LOAD) || (state_q == MUL) || (state_q == NEXT);
        done      = (state_q == DONE);
        interrupt = done & intr_en_q;
    end

    // Datapath and register file next-state
    always_comb begin
        acc_d      = acc_q;
        psum_d     = psum_q;
        k_d        = k_q;
        m_d        = m_q;
        fsh_d      = fsh_q;
        cnt_d      = cnt_q;
        operand_d  = operand_q;
        basev_d    = basev_q;
        mode_d     = mode_q;
        run_mode_d = run_mode_q;
        intr_en_d  = intr_en_q;
        ovf_d      = ovf_q;

        if (wr_en) begin
            case (off)
                OFF_INTR:    intr_en_d = s_din[0];
                OFF_OPERAND: operand_d = s_din[DW-1:0];
                OFF_MODE:    mode_d    = s_din[0];
                OFF_BASEV:   basev_d   = s_din[DW-1:0];
                default:     ;
            endcase
        end

        if (clear_wr) begin
            acc_d = RW'(1);
            ovf_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_wr) ovf_d = 1'b0;
                end
                LOAD: begin
                    acc_d      = RW'(1);
                    run_mode_d = mode_q;
                    k_d        = k_load;
                    m_d        = m_load;
                    fsh_d      = k_load;
                    psum_d     = '0;
                    cnt_d      = '0;
                end
                MUL: begin
                    // MSB-first shift-add; psum is wide enough to hold the
                    // full product so overflow can be inspected in NEXT.
                    psum_d = {psum_q[PW-2:0], 1'b0}
                           + (fsh_q[DW-1] ? {{DW{1'b0}}, acc_q} : '0);
                    fsh_d  = {fsh_q[DW-2:0], 1'b0};
                    cnt_d  = cnt_q + CW'(1);
                end
                NEXT: begin
                    acc_d = psum_q[RW-1:0];
                    if (|psum_q[PW-1:RW]) ovf_d = 1'b1;
                    m_d    = m_q - DW'(1);
                    k_d    = k_next;
                    fsh_d  = k_next;
                    psum_d = '0;
                    cnt_d  = '0;
                end
                default: ;
            endcase
        end
    end

    // Read mux; unmapped and write-only offsets read as zero
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_STATUS:  rd_data = {61'd0, ovf_q, busy, done};
            OFF_INTR:    rd_data = {63'd0, intr_en_q};
            OFF_OPERAND: rd_data = zext(operand_q);
            OFF_RES_H:   rd_data = zext(acc_q[RW-1:DW]);
            OFF_RES_L:   rd_data = zext(acc_q[DW-1:0]);
            OFF_MODE:    rd_data = {63'd0, mode_q};
            OFF_BASEV:   rd_data = zext(basev_q);
            default:     rd_data = '0;
        endcase
        s_dout_d = rd_en ? rd_data : '0;
    end

    // Datapath and register file flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= RW'(1);
            psum_q     <= '0;
            k_q        <= '0;
            m_q        <= '0;
            fsh_q      <= '0;
            cnt_q      <= '0;
            operand_q  <= '0;
            basev_q    <= '0;
            mode_q     <= 1'b0;
            run_mode_q <= 1'b0;
            intr_en_q  <= 1'b0;
            ovf_q      <= 1'b0;
            s_dout_q   <= '0;
        end else begin
            acc_q      <= acc_d;
            psum_q     <= psum_d;
            k_q        <= k_d;
            m_q        <= m_d;
            fsh_q      <= fsh_d;
            cnt_q      <= cnt_d;
            operand_q  <= operand_d;
            basev_q    <= basev_d;
            mode_q     <= mode_d;
            run_mode_q <= run_mode_d;
            intr_en_q  <= intr_en_d;
            ovf_q      <= ovf_d;
            s_dout_q   <= s_dout_d;
        end
    end

endmodule

// File: tb/tb_facto_core_gen.sv
// ---------------------------------------------------------------------------
// tb_facto_core_gen
// Directed bench for facto_core_gen (DW=64). Reads push their expected value
// into a scoreboard queue; a monitor pops and compares one cycle later when
// the registered read data appears.
// ---------------------------------------------------------------------------
module tb_facto_core_gen;

    localparam int DW = 64;

    localparam int R_START   = 0;
    localparam int R_CLEAR   = 1;
    localparam int R_STATUS  = 2;
    localparam int R_INTR    = 3;
    localparam int R_OPERAND = 4;
    localparam int R_RES_H   = 5;
    localparam int R_RES_L   = 6;
    localparam int R_MODE    = 7;
    localparam int R_BASEV   = 8;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        s_sel   = 1'b0;
    logic        s_wr    = 1'b0;
    logic [15:0] s_addr  = '0;
    logic [63:0] s_din   = '0;
    logic [63:0] s_dout;
    logic        interrupt;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic rd_vld       = 1'b0;

    facto_core_gen #(.DW(DW), .BASE(13'hE00)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_sel     (s_sel),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_din     (s_din),
        .s_dout    (s_dout),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    // Tracks which edges captured a read so the monitor knows when to pop
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_vld <= 1'b0;
        else          rd_vld <= s_sel & ~s_wr;
    end

    task automatic check_output(input string name, input logic [63:0] got,
                                input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Monitor: compares registered read data against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rd_vld) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_read got=0x%0h want=none", s_dout);
            end else begin
                e = sb_q.pop_front();
                check_output(e.name, s_dout, e.val);
            end
        end
    end

    function automatic logic [15:0] reg_addr(input int n);
        logic [12:0] o;
        o = 13'hE00 + 13'(n);
        return {o, 3'b000};
    endfunction

    task automatic write_reg(input int n, input logic [63:0] d);
        s_sel  = 1'b1;
        s_wr   = 1'b1;
        s_addr = reg_addr(n);
        s_din  = d;
        @(negedge clk);
        s_sel  = 1'b0;
        s_wr   = 1'b0;
        s_din  = '0;
    endtask

    task automatic read_reg(input int n, input string name, input logic [63:0] want);
        exp_t e;
        e.name = name;
        e.val  = want;
        sb_q.push_back(e);
        s_sel  = 1'b1;
        s_wr   = 1'b0;
        s_addr = reg_addr(n);
        @(negedge clk);
        s_sel  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_intr(input string name, input logic want);
        check_output(name, {63'd0, interrupt}, {63'd0, want});
    endtask

    // START, then read STATUS at exactly start+lat (still busy) and
    // start+lat+1 (done).
    task automatic start_and_wait(input string tag, input int lat,
                                  input logic [63:0] st_busy,
                                  input logic [63:0] st_done,
                                  input logic intr_exp);
        write_reg(R_START, 64'd1);
        check_intr({tag, "_intr_busy"}, 1'b0);
        idle(lat - 1);
        read_reg(R_STATUS, {tag, "_status_busy"}, st_busy);
        check_intr({tag, "_intr_done"}, intr_exp);
        read_reg(R_STATUS, {tag, "_status_done"}, st_done);
    endtask

    // Reference model using the wide multiply operator
    task automatic model_run(input bit mode, input logic [63:0] op,
                             input logic [63:0] bv,
                             output logic [127:0] acc, output bit ovf);
        logic [191:0] prod;
        logic [63:0]  k;
        logic [63:0]  m;
        acc = 128'd1;
        ovf = 1'b0;
        k   = mode ? bv : op;
        m   = mode ? op : ((op == 64'd0) ? 64'd0 : op - 64'd1);
        for (int i = 0; i < int'(m); i++) begin
            prod = {64'd0, acc} * {128'd0, k};
            if (prod[191:128] != 64'd0) ovf = 1'b1;
            acc = prod[127:0];
            if (!mode) k = k - 64'd1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] f30;
        logic [127:0] mdl_acc;
        bit           mdl_ovf;

        // Reset state
        #1 reset_n = 1'b0;
        @(negedge clk);
        check_output("rst_dout", s_dout, 64'd0);
        check_intr("rst_intr", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        read_reg(R_STATUS,  "rst_status",  64'd0);
        read_reg(R_RES_L,   "rst_res_l",   64'd1);
        read_reg(R_RES_H,   "rst_res_h",   64'd0);
        read_reg(R_INTR,    "rst_intr_en", 64'd0);
        read_reg(R_OPERAND, "rst_operand", 64'd0);
        read_reg(R_MODE,    "rst_mode",    64'd0);
        read_reg(R_BASEV,   "rst_basev",   64'd0);
        read_reg(9,         "unmapped",    64'd0);
        idle(1);
        check_output("no_read_dout", s_dout, 64'd0);

        // 5! = 120 after 1 + 4*65 edges
        write_reg(R_OPERAND, 64'd5);
        start_and_wait("f5", 261, 64'd2, 64'd1, 1'b0);
        read_reg(R_RES_L, "f5_res_l", 64'd120);
        read_reg(R_RES_H, "f5_res_h", 64'd0);

        // 0! and 1! finish one edge after START, interrupt with done
        write_reg(R_INTR, 64'd1);
        write_reg(R_OPERAND, 64'd0);
        start_and_wait("f0", 1, 64'd2, 64'd1, 1'b1);
        read_reg(R_RES_L, "f0_res_l", 64'd1);
        write_reg(R_OPERAND, 64'd1);
        start_and_wait("f1", 1, 64'd2, 64'd1, 1'b1);
        read_reg(R_RES_L, "f1_res_l", 64'd1);
        read_reg(R_INTR, "intr_en_rd", 64'd1);
        write_reg(R_INTR, 64'd0);
        check_intr("intr_off", 1'b0);

        // 30! fits exactly
        f30 = 128'd265252859812191058636308480000000;
        write_reg(R_OPERAND, 64'd30);
        start_and_wait("f30", 1886, 64'd2, 64'd1, 1'b0);
        read_reg(R_RES_H, "f30_res_h", f30[127:64]);
        read_reg(R_RES_L, "f30_res_l", f30[63:0]);

        // 35! exceeds 2^128: ovf set, result modulo 2^128
        model_run(1'b0, 64'd35, 64'd0, mdl_acc, mdl_ovf);
        write_reg(R_OPERAND, 64'd35);
        start_and_wait("f35", 2211, 64'd6, 64'd5, 1'b0);
        read_reg(R_RES_H, "f35_res_h", mdl_acc[127:64]);
        read_reg(R_RES_L, "f35_res_l", mdl_acc[63:0]);

        // Power mode: 3^4 = 81
        write_reg(R_MODE, 64'd1);
        write_reg(R_BASEV, 64'd3);
        write_reg(R_OPERAND, 64'd4);
        start_and_wait("p3_4", 261, 64'd2, 64'd1, 1'b0);
        read_reg(R_RES_L, "p3_4_res_l", 64'd81);
        read_reg(R_RES_H, "p3_4_res_h", 64'd0);

        // 2^130 wraps to zero with ovf
        write_reg(R_BASEV, 64'd2);
        write_reg(R_OPERAND, 64'd130);
        start_and_wait("p2_130", 8451, 64'd6, 64'd5, 1'b0);
        read_reg(R_RES_L, "p2_130_res_l", 64'd0);
        read_reg(R_RES_H, "p2_130_res_h", 64'd0);

        // 0^0 = 1, ovf cleared by the new START
        write_reg(R_BASEV, 64'd0);
        write_reg(R_OPERAND, 64'd0);
        start_and_wait("p0_0", 1, 64'd2, 64'd1, 1'b0);
        read_reg(R_RES_L, "p0_0_res_l", 64'd1);

        // CLEAR mid-MUL aborts; configuration registers survive
        write_reg(R_MODE, 64'd0);
        write_reg(R_BASEV, 64'd7);
        write_reg(R_INTR, 64'd1);
        write_reg(R_OPERAND, 64'd5);
        write_reg(R_START, 64'd1);
        idle(20);
        write_reg(R_CLEAR, 64'd1);
        read_reg(R_STATUS,  "clr_status",  64'd0);
        read_reg(R_RES_L,   "clr_res_l",   64'd1);
        read_reg(R_OPERAND, "clr_operand", 64'd5);
        read_reg(R_BASEV,   "clr_basev",   64'd7);
        read_reg(R_INTR,    "clr_intr_en", 64'd1);

        // START while busy is ignored; OPERAND write does not disturb the run
        write_reg(R_START, 64'd1);
        idle(10);
        write_reg(R_START, 64'd1);
        write_reg(R_OPERAND, 64'd3);
        idle(248);
        read_reg(R_STATUS, "busy_start_status_busy", 64'd2);
        check_intr("busy_start_intr", 1'b1);
        read_reg(R_STATUS, "busy_start_status_done", 64'd1);
        read_reg(R_RES_L,   "busy_start_res_l",   64'd120);
        read_reg(R_OPERAND, "busy_start_operand", 64'd3);

        // Reset pulse mid-run restores reset values
        write_reg(R_MODE, 64'd1);
        write_reg(R_BASEV, 64'd3);
        write_reg(R_OPERAND, 64'd4);
        write_reg(R_START, 64'd1);
        idle(30);
        read_reg(R_OPERAND, "pre_rst_operand", 64'd4);
        #2 reset_n = 1'b0;
        #1;
        check_output("mid_rst_dout", s_dout, 64'd0);
        check_intr("mid_rst_intr", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        read_reg(R_STATUS,  "post_rst_status",  64'd0);
        read_reg(R_RES_L,   "post_rst_res_l",   64'd1);
        read_reg(R_RES_H,   "post_rst_res_h",   64'd0);
        read_reg(R_INTR,    "post_rst_intr_en", 64'd0);
        read_reg(R_MODE,    "post_rst_mode",    64'd0);
        read_reg(R_BASEV,   "post_rst_basev",   64'd0);
        read_reg(R_OPERAND, "post_rst_operand", 64'd0);
        write_reg(R_OPERAND, 64'd3);
        start_and_wait("f3", 131, 64'd2, 64'd1, 1'b0);
        read_reg(R_RES_L, "f3_res_l", 64'd6);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain got=%0d pending want=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
